bitstream_byte_serializer: RTL and testbench
============================================

// Module: bitstream_byte_serializer
// PURPOSE
//  Expands the encoder's compressed per-cycle output bundle (OUT_BIT_1..5 + 3-bit flag) into a plain
//  byte stream with a valid/ready handshake. Sits after entropy_encoder; a descriptor FIFO absorbs bursts
//  because the encoder has no backpressure. Also reports end-of-frame (flag_last), a per-frame byte count
//  and sticky error flags. Hardware successor of the bench-side bitstream expansion, generalised in width and depth.
// PARAMETERS
//  SER_BITSTREAM_WIDTH  8   width of every in_bit_* and out_byte; in_bit_3 is also the run count
//  SER_FIFO_DEPTH       8   descriptor FIFO entries, power of two, >=2
//  SER_CNT_WIDTH        24  width of out_byte_count
// PORTS
//  top_clk          in   1    clock, rising edge
//  top_reset        in   1    asynchronous, active-high reset
//  in_bit_1..in_bit_5 in  W   encoder bitstream words (W = SER_BITSTREAM_WIDTH)
//  in_flag          in   3    encoder OUT_FLAG_BITSTREAM
//  in_flag_last     in   1    encoder OUT_FLAG_LAST (frame finished)
//  out_byte         out  W    byte to downstream
//  out_valid        out  1    out_byte valid
//  out_ready        in   1    downstream accepts when out_valid & out_ready
//  out_done         out  1    1-cycle pulse: all bytes of the frame accepted
//  out_byte_count   out  SER_CNT_WIDTH  bytes accepted in current frame
//  err_overflow     out  1    sticky: descriptor dropped, FIFO full
//  err_flag         out  1    sticky: in_flag==4 received
// BEHAVIOUR
//  Reset: async clear. FIFO empty, FSM IDLE, all outputs 0 (out_byte 0, counters 0, errors 0).
//  Flag code (emission order):
//   0 nothing; 1..3 in_bit_1..in_bit_<flag>;
//   5 in_bit_1, then in_bit_2 repeated in_bit_3 times (0 allowed);
//   6 as 5 then in_bit_4; 7 as 6 then in_bit_5; 4 illegal.
//  Capture: on each rising edge with in_flag in {1,2,3,5,6,7} or in_flag_last=1, push one descriptor
//   {bits 1..5, flag, last}. Flag and last together: bytes first, then frame end.
//   in_flag==4: set err_flag and store flag as 0; last bit still honoured.
//  FIFO: push and pop in the same cycle are legal, including when full. Push when full with no pop:
//   drop the descriptor and set err_overflow. Pointers wrap modulo SER_FIFO_DEPTH.
//  FSM states: IDLE, DIRECT (index 1..flag), HEAD (bit_1), RUN (down-counter loaded from bit_3),
//   T4, T5, DONE.
//   IDLE + FIFO non-empty -> pop. Flag 1..3 -> DIRECT; 5..7 -> HEAD; 0 -> DONE if last, else IDLE.
//   HEAD -> RUN, or straight to T4/T5/end when bit_3==0. RUN -> T4 (6,7) or end (5) when count hits 0.
//   T4 -> T5 (7) or end. End of a descriptor -> DONE if last, else pop next / IDLE.
//   DONE: out_done=1 for one cycle; out_byte_count shown with the final frame value, cleared next cycle.
//  Handshake: out_byte and out_valid are registered. Each state advances only when out_valid & out_ready.
//   out_byte must stay stable while out_valid & ~out_ready.
//   When the last byte of a descriptor is accepted and the FIFO is non-empty, pop next in the same cycle.
//   Sustained rate is 1 byte/cycle, no bubble between descriptors.
//  Latency: descriptor captured at edge k into an empty FIFO with FSM IDLE -> out_valid after edge k+2.
//  out_byte_count: +1 per accepted byte; wraps modulo 2^SER_CNT_WIDTH; cleared on reset and after out_done.
//  Errors: sticky until top_reset.
//  Reset mid-frame: discards everything in flight immediately; no out_done is produced.
// TESTING
//  T1 flag=3, bits 0x11,0x22,0x33, ready=1 -> bytes 11,22,33 on consecutive cycles; first valid 2 edges after capture.
//  T2 flag=7, b1=0xA0, b2=0xFF, b3=4, b4=0x01, b5=0x02 -> A0,FF,FF,FF,FF,01,02; count=7.
//  T3 flag=6 with b3=0 -> only b1,b4; then flag=5 with b3=0 -> only b1; no empty valid cycles.
//  T4 random out_ready (50%), 1000 random descriptors -> byte stream equals bench model; data stable while stalled.
//  T5 ready=0 with DEPTH+1 pushes -> err_overflow=1; the first DEPTH descriptors still drained intact.
//  T6 flag=2 with in_flag_last=1 in same cycle -> 2 bytes, then out_done with count=2; flag=4 -> err_flag=1, no byte.

Source files
------------

// File: rtl/bitstream_byte_serializer.sv
// Expands compressed encoder descriptors (five words + flag + last) into a
// valid/ready byte stream, with a descriptor FIFO, frame byte counter and sticky errors.
module bitstream_byte_serializer #(
  parameter int unsigned SER_BITSTREAM_WIDTH = 8,
  parameter int unsigned SER_FIFO_DEPTH      = 8,
  parameter int unsigned SER_CNT_WIDTH       = 24
) (
  input  logic                           top_clk,
  input  logic                           top_reset,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                     in_flag,
  input  logic                           in_flag_last,
  output logic [SER_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_done,
  output logic [SER_CNT_WIDTH-1:0]       out_byte_count,
  output logic                           err_overflow,
  output logic                           err_flag
);

  localparam int unsigned W  = SER_BITSTREAM_WIDTH;
  localparam int unsigned AW = (SER_FIFO_DEPTH > 1) ? $clog2(SER_FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [W-1:0] b1;
    logic [W-1:0] b2;
    logic [W-1:0] b3;
    logic [W-1:0] b4;
    logic [W-1:0] b5;
    logic [2:0]   flag;
    logic         last;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DIRECT, S_HEAD, S_RUN, S_T4, S_T5, S_DONE
  } state_t;

  desc_t          mem [SER_FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  desc_t          cap_desc_c;
  desc_t          head_c;
  logic           fifo_empty_c;
  logic           fifo_full_c;
  logic           cap_req_c;
  logic           push_c;
  logic           pop_c;

  state_t         state;
  desc_t          cur;
  logic [1:0]     idx;
  logic [W-1:0]   run_cnt;
  logic           gen_ok_c;
  logic           accept_c;
  logic           emit_c;
  logic           end_c;
  logic [W-1:0]   byte_c;
  state_t         fin_c;

  // Capture: flag 4 is recorded as "no bytes" but its last bit still counts
  assign cap_req_c    = ((in_flag != 3'd0) && (in_flag != 3'd4)) || in_flag_last;
  assign cap_desc_c   = '{b1: in_bit_1, b2: in_bit_2, b3: in_bit_3, b4: in_bit_4, b5: in_bit_5,
                          flag: (in_flag == 3'd4) ? 3'd0 : in_flag, last: in_flag_last};
  assign fifo_empty_c = (level == '0);
  assign fifo_full_c  = (level == LW'(SER_FIFO_DEPTH));
  assign push_c       = cap_req_c && (!fifo_full_c || pop_c);
  assign head_c       = mem[rd_ptr];

  always_ff @(posedge top_clk) begin
    if (push_c) mem[wr_ptr] <= cap_desc_c;
  end

  always_ff @(posedge top_clk or posedge top_reset) begin
    if (top_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  function automatic state_t entry_state(input desc_t d);
    case (d.flag)
      3'd1, 3'd2, 3'd3: return S_DIRECT;
      3'd5, 3'd6, 3'd7: return S_HEAD;
      default:          return d.last ? S_DONE : S_IDLE;
    endcase
  endfunction

  assign gen_ok_c = !out_valid || out_ready;
  assign accept_c = out_valid && out_ready;
  assign fin_c    = cur.last ? S_DONE : S_IDLE;

  // Byte generator: one byte per free output slot, end_c marks a descriptor's final byte
  always_comb begin
    emit_c = 1'b0;
    end_c  = 1'b0;
    byte_c = '0;
    case (state)
      S_DIRECT: begin
        emit_c = gen_ok_c;
        byte_c = (idx == 2'd1) ? cur.b1 : (idx == 2'd2) ? cur.b2 : cur.b3;
        end_c  = (idx == cur.flag[1:0]);
      end
      S_HEAD: begin
        emit_c = gen_ok_c;
        byte_c = cur.b1;
        end_c  = (cur.flag == 3'd5) && (cur.b3 == '0);
      end
      S_RUN: begin
        emit_c = gen_ok_c;
        byte_c = cur.b2;
        end_c  = (cur.flag == 3'd5) && (run_cnt == W'(1));
      end
      S_T4: begin
        emit_c = gen_ok_c;
        byte_c = cur.b4;
        end_c  = (cur.flag != 3'd7);
      end
      S_T5: begin
        emit_c = gen_ok_c;
        byte_c = cur.b5;
        end_c  = 1'b1;
      end
      default: ;
    endcase
    pop_c = !fifo_empty_c &&
            ((state == S_IDLE) || (emit_c && end_c && !cur.last));
  end

  always_ff @(posedge top_clk or posedge top_reset) begin
    if (top_reset) begin
      state          <= S_IDLE;
      cur            <= '0;
      idx            <= 2'd0;
      run_cnt        <= '0;
      out_byte       <= '0;
      out_valid      <= 1'b0;
      out_done       <= 1'b0;
      out_byte_count <= '0;
      err_overflow   <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      out_done <= 1'b0;

      if (emit_c) begin
        out_valid <= 1'b1;
        out_byte  <= byte_c;
      end else if (accept_c) begin
        out_valid <= 1'b0;
      end

      if (out_done)      out_byte_count <= '0;
      else if (accept_c) out_byte_count <= out_byte_count + SER_CNT_WIDTH'(1);

      if (in_flag == 3'd4) err_flag <= 1'b1;
      if (cap_req_c && fifo_full_c && !pop_c) err_overflow <= 1'b1;

      // A pop always starts the next descriptor, whether from IDLE or chained
      if (pop_c) begin
        cur   <= head_c;
        idx   <= 2'd1;
        state <= entry_state(head_c);
      end else begin
        case (state)
          S_DIRECT: if (emit_c) begin
            if (end_c) state <= fin_c;
            else       idx   <= idx + 2'd1;
          end
          S_HEAD: if (emit_c) begin
            if (cur.b3 != '0) begin
              run_cnt <= cur.b3;
              state   <= S_RUN;
            end else begin
              state <= (cur.flag == 3'd5) ? fin_c : S_T4;
            end
          end
          S_RUN: if (emit_c) begin
            run_cnt <= run_cnt - W'(1);
            if (run_cnt == W'(1)) state <= (cur.flag == 3'd5) ? fin_c : S_T4;
          end
          S_T4: if (emit_c) state <= (cur.flag == 3'd7) ? S_T5 : fin_c;
          S_T5: if (emit_c) state <= fin_c;
          S_DONE: if (!out_valid || out_ready) begin
            out_done <= 1'b1;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitstream_byte_serializer.sv
// Directed and randomized bench for bitstream_byte_serializer; bytes are
// compared against a queue-based expansion of the flag rules.
module tb_bitstream_byte_serializer;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
  logic [2:0]    in_flag;
  logic          in_flag_last;
  logic [W-1:0]  out_byte;
  logic          out_valid;
  logic          out_ready;
  logic          out_done;
  logic [CW-1:0] out_byte_count;
  logic          err_overflow;
  logic          err_flag;

  bitstream_byte_serializer #(
    .SER_BITSTREAM_WIDTH(W), .SER_FIFO_DEPTH(DEPTH), .SER_CNT_WIDTH(CW)
  ) dut (
    .top_clk(clk), .top_reset(rst),
    .in_bit_1(in_bit_1), .in_bit_2(in_bit_2), .in_bit_3(in_bit_3),
    .in_bit_4(in_bit_4), .in_bit_5(in_bit_5),
    .in_flag(in_flag), .in_flag_last(in_flag_last),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_done(out_done), .out_byte_count(out_byte_count),
    .err_overflow(err_overflow), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           desc_left[$];
  logic [W-1:0] rx_q[$];
  bit           compare_mode = 1'b1;
  int           ready_pct = 100;
  int           model_cnt = 0;
  bit           pend_accept = 1'b0;
  bit           pend_clear = 1'b0;
  int           done_seen = 0;
  int           last_done_cnt = 0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_byte = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference expansion of one descriptor straight from the flag table
  function automatic void expand(input logic [2:0] f, input logic [W-1:0] a, b, c, d, e);
    logic [W-1:0] w[5];
    int n = 0;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
    if (f >= 3'd1 && f <= 3'd3) begin
      for (int i = 0; i < int'(f); i++) begin exp_q.push_back(w[i]); n++; end
    end else if (f >= 3'd5) begin
      exp_q.push_back(a); n++;
      for (int i = 0; i < int'(c); i++) begin exp_q.push_back(b); n++; end
      if (f >= 3'd6) begin exp_q.push_back(d); n++; end
      if (f == 3'd7) begin exp_q.push_back(e); n++; end
    end
    if (n > 0) desc_left.push_back(n);
  endfunction

  task automatic monitor();
    if (pend_clear) begin model_cnt = 0; pend_clear = 1'b0; end
    if (pend_accept) begin model_cnt++; pend_accept = 1'b0; end
    chk("byte_count", 32'(out_byte_count), 32'(model_cnt));
    if (out_done) begin done_seen++; last_done_cnt = int'(out_byte_count); pend_clear = 1'b1; end
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_byte", 32'(out_byte), 32'(prev_byte));
    end
    out_ready = ($urandom_range(0, 99) < ready_pct);
    prev_stall = out_valid && !out_ready;
    prev_byte = out_byte;
    if (out_valid && out_ready) begin
      pend_accept = 1'b1;
      if (compare_mode) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(exp_q.size()), 32'd1);
        else begin
          chk("byte", 32'(out_byte), 32'(exp_q.pop_front()));
          desc_left[0] = desc_left[0] - 1;
          if (desc_left[0] == 0) void'(desc_left.pop_front());
        end
      end else begin
        rx_q.push_back(out_byte);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    in_flag = 3'd0;
    in_flag_last = 1'b0;
    monitor();
  endtask

  task automatic push(input logic [2:0] f, input logic l, input logic [W-1:0] a, b, c, d, e);
    in_flag = f; in_flag_last = l;
    in_bit_1 = a; in_bit_2 = b; in_bit_3 = c; in_bit_4 = d; in_bit_5 = e;
    if (compare_mode && f != 3'd4) expand(f, a, b, c, d, e);
    cycle();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_count"}, 32'(out_byte_count), 32'd0);
    chk({tag, "_done"}, 32'(out_done), 32'd0);
    exp_q.delete(); desc_left.delete(); rx_q.delete();
    model_cnt = 0; pend_accept = 1'b0; pend_clear = 1'b0; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic wait_done(input string tag, input int exp_cnt);
    int d0 = done_seen;
    int n = 0;
    while (done_seen == d0 && n < 300) begin cycle(); n++; end
    chk({tag, "_done"}, 32'(done_seen - d0), 32'd1);
    chk({tag, "_count"}, 32'(last_done_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int pushed;
    int d0;
    int m;
    int fs[6];
    logic [2:0] f;
    fs[0] = 1; fs[1] = 2; fs[2] = 3; fs[3] = 5; fs[4] = 6; fs[5] = 7;

    rst = 1'b1;
    in_bit_1 = '0; in_bit_2 = '0; in_bit_3 = '0; in_bit_4 = '0; in_bit_5 = '0;
    in_flag = 3'd0; in_flag_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_byte", 32'(out_byte), 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_count", 32'(out_byte_count), 32'd0);
    chk("rst_err_ovf", 32'(err_overflow), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // T1: three direct bytes, two-edge latency, back-to-back
    push(3'd3, 1'b0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
    chk("t1_lat_k", 32'(out_valid), 32'd0);
    cycle(); chk("t1_lat_k1", 32'(out_valid), 32'd0);
    cycle(); chk("t1_lat_k2", 32'(out_valid), 32'd1); chk("t1_b0", 32'(out_byte), 32'h11);
    cycle(); chk("t1_v1", 32'(out_valid), 32'd1); chk("t1_b1", 32'(out_byte), 32'h22);
    cycle(); chk("t1_v2", 32'(out_valid), 32'd1); chk("t1_b2", 32'(out_byte), 32'h33);
    cycle(); chk("t1_end", 32'(out_valid), 32'd0);
    push(3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done("t1_frame", 3);

    // T2: run-length with tails
    push(3'd7, 1'b1, 8'hA0, 8'hFF, 8'h04, 8'h01, 8'h02);
    wait_done("t2", 7);

    // T3: zero-length runs, no empty valid cycles between descriptors
    push(3'd6, 1'b0, 8'h31, 8'h32, 8'h00, 8'h34, 8'h35);
    push(3'd5, 1'b0, 8'h51, 8'h52, 8'h00, 8'h54, 8'h55);
    cycle();
    for (int i = 0; i < 3; i++) begin chk("t3_valid", 32'(out_valid), 32'd1); cycle(); end
    chk("t3_idle", 32'(out_valid), 32'd0);
    chk("t3_all_out", 32'(exp_q.size()), 32'd0);

    // T4: random descriptors under 50% backpressure
    ready_pct = 50;
    d0 = done_seen;
    pushed = 0;
    for (int cyc = 0; cyc < 60000 && pushed < 1000; cyc++) begin
      if (desc_left.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        f = 3'(fs[$urandom_range(0, 5)]);
        push(f, 1'b0, 8'($urandom), 8'($urandom),
             (f >= 3'd5) ? 8'($urandom_range(0, 5)) : 8'($urandom),
             8'($urandom), 8'($urandom));
        pushed++;
      end else begin
        cycle();
      end
    end
    chk("t4_pushed", 32'(pushed), 32'd1000);
    for (int cyc = 0; cyc < 20000 && exp_q.size() > 0; cyc++) cycle();
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_no_ovf", 32'(err_overflow), 32'd0);
    chk("t4_no_errflag", 32'(err_flag), 32'd0);
    chk("t4_no_done", 32'(done_seen - d0), 32'd0);

    // T5: overflow with output stalled; surviving descriptors drain in order
    ready_pct = 0;
    do_reset("t5_rst");
    compare_mode = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 4; i++) push(3'd1, 1'b0, 8'(i), 8'h00, 8'h00, 8'h00, 8'h00);
    cycle();
    chk("t5_ovf", 32'(err_overflow), 32'd1);
    ready_pct = 100;
    repeat (40) cycle();
    m = rx_q.size();
    chk("t5_min_drained", 32'(m >= int'(DEPTH)), 32'd1);
    chk("t5_max_drained", 32'(m < int'(DEPTH) + 4), 32'd1);
    for (int i = 0; i < m; i++) chk("t5_order", 32'(rx_q[i]), 32'(i));
    chk("t5_ovf_sticky", 32'(err_overflow), 32'd1);

    // T6: flag+last together, then illegal flag
    do_reset("t6_rst");
    compare_mode = 1'b1;
    push(3'd2, 1'b1, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65);
    wait_done("t6", 2);
    cycle();
    chk("t6_count_clr", 32'(out_byte_count), 32'd0);
    push(3'd4, 1'b0, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75);
    chk("t6_err_flag", 32'(err_flag), 32'd1);
    for (int i = 0; i < 4; i++) begin chk("t6_no_byte", 32'(out_valid), 32'd0); cycle(); end
    push(3'd4, 1'b1, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85);
    wait_done("t6_illegal_last", 0);
    chk("t6_err_ovf_clear", 32'(err_overflow), 32'd0);

    // Reset mid-frame discards everything and produces no done
    push(3'd5, 1'b1, 8'h91, 8'h92, 8'd20, 8'h00, 8'h00);
    repeat (5) cycle();
    chk("mid_busy", 32'(out_valid), 32'd1);
    d0 = done_seen;
    do_reset("mid_rst");
    chk("mid_err_flag_clr", 32'(err_flag), 32'd0);
    repeat (30) cycle();
    chk("mid_no_done", 32'(done_seen - d0), 32'd0);
    chk("mid_idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
